seq_mult_hs: RTL and testbench

Parametrised shift-and-add sequential multiplier with valid/ready handshakes on both sides. It accepts full-width operands in one transfer and computes one partial product per clock. A per-operation mode bit selects signed (two's-complement) or unsigned arithmetic. The block sits between an operand-issuing producer and a result consumer, and is the general-width replacement for the fixed 16-bit, bit-serial multiplier.

---
 rtl/seq_mult_pkg.sv | 16 +
 rtl/seq_mult_ctrl.sv | 74 +++++++
 rtl/seq_mult_hs.sv | 88 ++++++++
 tb/tb_seq_mult_hs.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mult_pkg.sv
// Shared types and width helpers for the shift-and-add sequential multiplier.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int PROD_FACTOR = 2;

  function automatic int prod_width(input int w);
    return PROD_FACTOR * w;
  endfunction

endpackage

// File: rtl/seq_mult_ctrl.sv
// Sequencer for seq_mult_hs: state register, step counter and handshake decode.
import seq_mult_pkg::*;

module seq_mult_ctrl #(
  parameter int W  = 16,
  parameter int CW = $clog2(W)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_flush,
  input  logic          i_in_valid,
  input  logic          i_out_ready,
  output state_t        o_state,
  output logic [CW-1:0] o_cnt,
  output logic          o_step,
  output logic          o_last_step,
  output logic          o_load,
  output logic          o_clear
);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          w_in_ready;
  logic          w_accept;
  logic          w_last;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; ready depends on state only, and flush vetoes an input transfer.
  assign w_in_ready = (r_state == IDLE);
  assign w_accept   = i_in_valid & w_in_ready & ~i_flush;
  assign w_last     = (r_state == CALC) && (r_cnt == CW'(W - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else if (i_flush) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state <= CALC;
            r_cnt   <= '0;
          end
        end
        CALC: begin
          if (w_last) begin
            r_state <= DONE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DONE: begin
          if (i_out_ready) r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_state     = r_state;
  assign o_cnt       = r_cnt;
  assign o_step      = (r_state == CALC) & ~i_flush;
  assign o_last_step = w_last;
  assign o_load      = w_accept;
  assign o_clear     = i_flush;

endmodule

// File: rtl/seq_mult_hs.sv
// Shift-and-add sequential multiplier, one partial product per clock, with
// valid/ready on both sides and a per-operation signed/unsigned mode.
import seq_mult_pkg::*;

module seq_mult_hs #(
  parameter int W  = 16,
  parameter int CW = $clog2(W)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      op_signed,
  input  logic [W-1:0]              multiplicand,
  input  logic [W-1:0]              multiplier,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [prod_width(W)-1:0]  product
);

  localparam int PW = prod_width(W);

  state_t        w_state;
  logic [CW-1:0] w_cnt;
  logic          w_step;
  logic          w_last_step;
  logic          w_load;
  logic          w_clear;

  logic [PW-1:0] r_mcand;
  logic [W-1:0]  r_mplier;
  logic          r_signed;
  logic [PW-1:0] r_acc;

  logic [PW-1:0] w_mcand_ext;
  logic [PW-1:0] w_addend;
  logic          w_sub;
  logic [PW-1:0] w_acc_next;

  seq_mult_ctrl #(
    .W  (W),
    .CW (CW)
  ) u_ctrl (
    .clk         (clk),
    .reset       (reset),
    .i_flush     (flush),
    .i_in_valid  (in_valid),
    .i_out_ready (out_ready),
    .o_state     (w_state),
    .o_cnt       (w_cnt),
    .o_step      (w_step),
    .o_last_step (w_last_step),
    .o_load      (w_load),
    .o_clear     (w_clear)
  );

  assign w_mcand_ext = op_signed ? {{W{multiplicand[W-1]}}, multiplicand}
                                 : {{W{1'b0}}, multiplicand};

  // The multiplier MSB carries negative weight in two's complement.
  assign w_addend   = r_mcand << w_cnt;
  assign w_sub      = w_last_step & r_signed;
  assign w_acc_next = w_sub ? (r_acc - w_addend) : (r_acc + w_addend);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_signed <= 1'b0;
      r_acc    <= '0;
    end else if (w_clear) begin
      r_acc <= '0;
    end else if (w_load) begin
      r_mcand  <= w_mcand_ext;
      r_mplier <= multiplier;
      r_signed <= op_signed;
      r_acc    <= '0;
    end else if (w_step && r_mplier[w_cnt]) begin
      r_acc <= w_acc_next;
    end
  end

  assign in_ready  = (w_state == IDLE);
  assign out_valid = (w_state == DONE);
  assign product   = r_acc;

endmodule

// File: tb/tb_seq_mult_hs.sv
// Self-checking bench for seq_mult_hs at W = 16: vector table, random ops
// against a reference model, and hand-written multi-cycle corner sequences.
module tb_seq_mult_hs;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        op_signed;
  logic [15:0] multiplicand;
  logic [15:0] multiplier;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;

  logic [31:0] exp_q[$];
  int          total;
  int          bad;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[9];

  seq_mult_hs #(.W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .op_signed    (op_signed),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic s);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [31:0]        ua;
    logic [31:0]        ub;
    if (s) begin
      sa = $signed({{16{a[15]}}, a});
      sb = $signed({{16{b[15]}}, b});
      return 32'(sa * sb);
    end
    ua = {16'd0, a};
    ub = {16'd0, b};
    return ua * ub;
  endfunction

  // driver: present one operand pair at a negedge, leave it for one edge
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic s,
                      input logic [31:0] e, input bit push);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("send_in_ready", 32'(in_ready), 32'd1);
    in_valid     = 1'b1;
    multiplicand = a;
    multiplier   = b;
    op_signed    = s;
    if (push) exp_q.push_back(e);
    @(negedge clk);
    in_valid     = 1'b0;
    multiplicand = 16'($urandom);
    multiplier   = 16'($urandom);
    op_signed    = 1'($urandom_range(0, 1));
  endtask

  // receiver: called right after send; optional latency check and backpressure
  task automatic recv(input bit chk_lat, input int hold);
    int          cyc;
    logic [31:0] e;
    cyc = 0;
    e   = 32'd0;
    check("busy_in_ready", 32'(in_ready), 32'd0);
    while (!out_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("out_valid_seen", 32'(out_valid), 32'd1);
    if (chk_lat) check("latency", 32'(cyc), 32'd16);
    check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) e = exp_q.pop_front();
    check("product", product, e);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_product", product, e);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_drop", 32'(out_valid), 32'd0);
    check("in_ready_back", 32'(in_ready), 32'd1);
    check("product_kept", product, e);
  endtask

  initial begin
    bit seen;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rs;

    total = 0;
    bad   = 0;
    vecs[0] = '{16'hFFFD, 16'h0005, 1'b1, 32'hFFFFFFF1};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001};
    vecs[3] = '{16'h8000, 16'h8000, 1'b1, 32'h40000000};
    vecs[4] = '{16'h7FFF, 16'h8000, 1'b1, 32'hC0008000};
    vecs[5] = '{16'h0064, 16'h00C8, 1'b0, 32'h00004E20};
    vecs[6] = '{16'h0000, 16'hFFFF, 1'b1, 32'h00000000};
    vecs[7] = '{16'h8000, 16'h0001, 1'b0, 32'h00008000};
    vecs[8] = '{16'hFFFF, 16'h0002, 1'b1, 32'hFFFFFFFE};

    reset        = 1'b0;
    flush        = 1'b0;
    in_valid     = 1'b0;
    op_signed    = 1'b0;
    multiplicand = 16'd0;
    multiplier   = 16'd0;
    out_ready    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_product", product, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp, 1'b1);
      recv(1'b1, 0);
    end

    for (int i = 0; i < 8; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom_range(0, 1));
      send(ra, rb, rs, model(ra, rb, rs), 1'b1);
      recv(1'b1, $urandom_range(0, 3));
    end

    // backpressure for 10 cycles, then back-to-back operations
    send(16'd7, 16'd9, 1'b0, 32'd63, 1'b1);
    recv(1'b1, 10);
    send(16'd12, 16'd12, 1'b0, 32'd144, 1'b1);
    recv(1'b1, 0);

    // flush at step 8 with a competing in_valid
    send(16'h1234, 16'hFFFF, 1'b0, 32'd0, 1'b0);
    repeat (8) @(negedge clk);
    flush        = 1'b1;
    in_valid     = 1'b1;
    multiplicand = 16'd5;
    multiplier   = 16'd5;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_in_ready", 32'(in_ready), 32'd1);
    check("flush_product", product, 32'd0);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("flush_no_out", 32'(seen), 32'd0);
    send(16'd2, 16'd3, 1'b0, 32'd6, 1'b1);
    recv(1'b1, 0);

    // asynchronous reset at step 5
    send(16'h1234, 16'hFFFF, 1'b0, 32'd0, 1'b0);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_product", product, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send(16'd100, 16'd200, 1'b0, 32'h00004E20, 1'b1);
    recv(1'b1, 0);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
